// File: rtl/jtframe_dump_pkg.sv
// Shared types and default widths for the jtframe trace capture scheduler.
package jtframe_dump_pkg;
    localparam int DW_DEF = 16;
    localparam int AW_DEF = 10;
    localparam int FW_DEF = 16;

    typedef enum logic [2:0] {IDLE, WAIT_DL, ARMED, CAPTURE, DONE} dump_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
endpackage

// File: rtl/jtframe_dump_frmcnt.sv
// Frame counter: counts falling edges of vertical sync, cleared when a ROM download ends.
module jtframe_dump_frmcnt
    import jtframe_dump_pkg::*;
#(
    parameter int FW = FW_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          downloading,
    output logic          vs_fall,
    output logic [FW-1:0] frame_cnt
);
    logic vs_p1;
    logic dl_p1;
    logic dl_fall;

    assign vs_fall = vs_p1 & ~vs;
    assign dl_fall = dl_p1 & ~downloading;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_p1     <= 1'b0;
            dl_p1     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_p1 <= vs;
            dl_p1 <= downloading;
            // The end of a download restarts frame numbering even if a frame ends in the same cycle
            if (dl_fall)
                frame_cnt <= '0;
            else if (vs_fall)
                frame_cnt <= frame_cnt + FW'(1);
        end
    end
endmodule

// File: rtl/jtframe_dump_sched.sv
// Trace capture scheduler: opens a window at a chosen frame, writes probe samples to an
// external BRAM, then streams the captured words out through a req/ack readout.
module jtframe_dump_sched
    import jtframe_dump_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int FW = FW_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic          downloading,
    input  logic          cen,
    input  logic          arm,
    input  logic [FW-1:0] start_frame,
    input  logic [FW-1:0] nframes,
    input  logic [DW-1:0] probe,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_din,
    input  logic [DW-1:0] buf_dout,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic [FW-1:0] frame_cnt,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [AW:0]   used
);
    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

    dump_state_t   state;
    rd_state_t     rd_st;
    logic [AW:0]   rp;
    logic [FW-1:0] win_cnt;
    logic [FW-1:0] win_nx;
    logic [FW-1:0] frame_nx;
    logic          vs_fall;

    jtframe_dump_frmcnt #(.FW(FW)) u_frmcnt (
        .clk        (clk),
        .rst        (rst),
        .vs         (vs),
        .downloading(downloading),
        .vs_fall    (vs_fall),
        .frame_cnt  (frame_cnt)
    );

    assign frame_nx = frame_cnt + FW'(1);
    assign win_nx   = win_cnt + FW'(1);
    assign busy     = (state == ARMED) || (state == CAPTURE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_st    <= RD_IDLE;
            rp       <= '0;
            win_cnt  <= '0;
            used     <= '0;
            ovf      <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_din  <= '0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
        end else begin
            buf_we <= 1'b0;
            rd_ack <= 1'b0;
            if (arm) begin
                // A new session from any state; a finished buffer keeps its last address
                state <= WAIT_DL;
                rd_st <= RD_IDLE;
                rp    <= '0;
                used  <= '0;
                ovf   <= 1'b0;
                if (state != DONE) buf_addr <= '0;
            end else begin
                case (state)
                    WAIT_DL: if (!downloading) state <= ARMED;
                    ARMED: begin
                        if (downloading)
                            state <= WAIT_DL;
                        else if (vs_fall && frame_nx == start_frame) begin
                            state   <= CAPTURE;
                            win_cnt <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (downloading) begin
                            state <= WAIT_DL;
                            ovf   <= 1'b0;
                        end else begin
                            if (cen) begin
                                buf_we   <= 1'b1;
                                buf_din  <= probe;
                                buf_addr <= used[AW-1:0];
                                used     <= used + (AW+1)'(1);
                                if (used == LAST) begin
                                    ovf   <= 1'b1;
                                    state <= DONE;
                                end
                            end
                            if (vs_fall) begin
                                win_cnt <= win_nx;
                                if (nframes != '0 && win_nx == nframes) state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        // Readout: address, BRAM latency, then data capture
                        case (rd_st)
                            RD_IDLE: if (rd_req && rp != used) begin
                                buf_addr <= rp[AW-1:0];
                                rd_st    <= RD_ADDR;
                            end
                            RD_ADDR: rd_st <= RD_DATA;
                            RD_DATA: begin
                                rd_ack  <= 1'b1;
                                rd_data <= buf_dout;
                                rp      <= rp + (AW+1)'(1);
                                rd_st   <= RD_IDLE;
                            end
                            default: rd_st <= RD_IDLE;
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
